// File: rtl/tsc_frame_ctrl_pkg.sv
// Shared definitions for the TSC frame sequencer and the TSC datapath.
package tsc_frame_ctrl_pkg;

    // Segments per frame; TSC sizes its alpha register chain from this.
    localparam int NUM_PHASE   = 3;
    // Phase counter width, wide enough for 0..NUM_PHASE-1.
    localparam int PHASE_CNT_W = 2;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } frame_state_e;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/tsc_frame_if.sv
// Beat/result handshakes and TSC control lines between the sequencer and its neighbours.
interface tsc_frame_if;
    logic in_llr_valid;
    logic out_llr_ready;
    logic out_tsc_Srst;
    logic out_tsc_en;
    logic out_tsc_init;
    logic out_tsc_phase_shift;
    logic out_res_valid;
    logic in_res_ready;

    // Sequencer side.
    modport slave (
        input  in_llr_valid,
        input  in_res_ready,
        output out_llr_ready,
        output out_tsc_Srst,
        output out_tsc_en,
        output out_tsc_init,
        output out_tsc_phase_shift,
        output out_res_valid
    );

    // Environment side: LLR buffer, TSC and test-pattern generator.
    modport master (
        output in_llr_valid,
        output in_res_ready,
        input  out_llr_ready,
        input  out_tsc_Srst,
        input  out_tsc_en,
        input  out_tsc_init,
        input  out_tsc_phase_shift,
        input  out_res_valid
    );
endinterface

// File: rtl/tsc_frame_ctrl_seg_counter.sv
// Two-level beat/phase counter: beats wrap every SEG_BEATS, phases every NUM_PHASE.
module tsc_frame_ctrl_seg_counter
    import tsc_frame_ctrl_pkg::*;
#(
    parameter int SEG_BEATS = 86
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_adv,
    output logic o_last_beat,
    output logic o_last_phase
);
    localparam int BEAT_CNT_W = cnt_width(SEG_BEATS);

    logic [BEAT_CNT_W-1:0]  r_beat_cnt;
    logic [PHASE_CNT_W-1:0] r_phase_cnt;

    assign o_last_beat  = (r_beat_cnt == BEAT_CNT_W'(SEG_BEATS - 1));
    assign o_last_phase = (r_phase_cnt == PHASE_CNT_W'(NUM_PHASE - 1));

    // Advance beat count per accepted beat; carry into phase at segment end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt  <= '0;
            r_phase_cnt <= '0;
        end else if (i_clr) begin
            r_beat_cnt  <= '0;
            r_phase_cnt <= '0;
        end else if (i_adv) begin
            if (o_last_beat) begin
                r_beat_cnt  <= '0;
                r_phase_cnt <= o_last_phase ? '0 : (r_phase_cnt + PHASE_CNT_W'(1));
            end else begin
                r_beat_cnt  <= r_beat_cnt + BEAT_CNT_W'(1);
            end
        end else begin
            r_beat_cnt  <= r_beat_cnt;
            r_phase_cnt <= r_phase_cnt;
        end
    end

endmodule

// File: rtl/tsc_frame_ctrl.sv
// Frame sequencer for the test syndrome computation block. SEG_BEATS must be >= 1.
module tsc_frame_ctrl
    import tsc_frame_ctrl_pkg::*;
#(
    parameter int SEG_BEATS = 86
) (
    input  logic        clk,
    input  logic        in_ctr_Arst_n,
    input  logic        in_start,
    input  logic        in_abort,
    tsc_frame_if.slave  bus,
    output logic        out_busy
);
    frame_state_e r_state;
    logic         w_last_beat;
    logic         w_last_phase;
    logic         w_beat_acc;
    logic         w_phase_shift;
    logic         w_cnt_clr;

    // A beat counts only in RUN and never in an abort cycle.
    assign w_beat_acc    = (r_state == ST_RUN) & bus.in_llr_valid & ~in_abort;
    // The shift lands on the segment's last beat so TSC compares it before capture.
    assign w_phase_shift = w_beat_acc & w_last_beat;
    assign w_cnt_clr     = in_abort | (r_state == ST_INIT);
    assign out_busy      = (r_state != ST_IDLE);

    tsc_frame_ctrl_seg_counter #(
        .SEG_BEATS (SEG_BEATS)
    ) u_seg_counter (
        .clk          (clk),
        .rst_n        (in_ctr_Arst_n),
        .i_clr        (w_cnt_clr),
        .i_adv        (w_beat_acc),
        .o_last_beat  (w_last_beat),
        .o_last_phase (w_last_phase)
    );

    // Frame state machine; abort overrides every transition.
    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            r_state <= ST_IDLE;
        end else if (in_abort) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= in_start ? ST_INIT : ST_IDLE;
                ST_INIT: r_state <= ST_RUN;
                ST_RUN:  r_state <= (w_phase_shift && w_last_phase) ? ST_DONE : ST_RUN;
                ST_DONE: r_state <= bus.in_res_ready ? ST_IDLE : ST_DONE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Decode TSC controls and handshakes from registered state plus beat valid and abort.
    always_comb begin
        bus.out_llr_ready       = 1'b0;
        bus.out_tsc_Srst        = 1'b0;
        bus.out_tsc_en          = 1'b0;
        bus.out_tsc_init        = 1'b0;
        bus.out_tsc_phase_shift = 1'b0;
        bus.out_res_valid       = 1'b0;
        if (in_abort) begin
            bus.out_tsc_Srst = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    bus.out_tsc_en = 1'b0;
                end
                ST_INIT: begin
                    bus.out_tsc_en   = 1'b1;
                    bus.out_tsc_init = 1'b1;
                end
                ST_RUN: begin
                    bus.out_llr_ready       = 1'b1;
                    bus.out_tsc_en          = bus.in_llr_valid;
                    bus.out_tsc_phase_shift = w_phase_shift;
                end
                ST_DONE: begin
                    bus.out_res_valid = 1'b1;
                end
                default: begin
                    bus.out_tsc_en = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tsc_frame_ctrl.sv
// Self-checking bench for tsc_frame_ctrl: frame-position model plus a minimum-tracking TSC stand-in.
`timescale 1ns/1ps
module tb_tsc_frame_ctrl;
    localparam int SEG    = 4;
    localparam int NBEATS = 3 * SEG;
    localparam int P_IDLE = -2;
    localparam int P_INIT = -1;
    localparam int P_DONE = NBEATS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic start1 = 1'b0;
    logic abort1 = 1'b0;
    logic busy1;

    tsc_frame_if bus ();
    tsc_frame_if bus1 ();

    tsc_frame_ctrl #(.SEG_BEATS(SEG)) dut (
        .clk           (clk),
        .in_ctr_Arst_n (rst_n),
        .in_start      (start),
        .in_abort      (abort),
        .bus           (bus),
        .out_busy      (busy)
    );

    tsc_frame_ctrl #(.SEG_BEATS(1)) dut1 (
        .clk           (clk),
        .in_ctr_Arst_n (rst_n),
        .in_start      (start1),
        .in_abort      (abort1),
        .bus           (bus1),
        .out_busy      (busy1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: position within the frame (idle, init, accepted-beat count, done).
    int m_pos = P_IDLE;
    logic [2:0] frame [NBEATS][4];
    logic [2:0] beat_sym [4];
    int exp_min [3];
    // TSC stand-in: running minimum and the three captured segment minima.
    int t_cur = 7;
    int t_a1 = 7;
    int t_a2 = 7;
    int t_a3 = 7;
    int vmode = 0;
    bit toggle = 1'b1;

    bit e_srst, e_en, e_init, e_ps, e_rdy, e_rv, e_busy;
    int nxt;
    int bmin;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model once per cycle, then advance model and TSC stand-in.
    always @(negedge clk) begin
        bmin = 7;
        for (int s = 0; s < 4; s++) if (int'(beat_sym[s]) < bmin) bmin = int'(beat_sym[s]);
        e_srst = 1'b0; e_en = 1'b0; e_init = 1'b0; e_ps = 1'b0;
        e_rdy = 1'b0; e_rv = 1'b0; e_busy = 1'b0;
        nxt = m_pos;
        if (!rst_n) begin
            nxt = P_IDLE;
        end else begin
            e_busy = (m_pos != P_IDLE);
            if (abort) begin
                e_srst = 1'b1;
                nxt = P_IDLE;
            end else if (m_pos == P_IDLE) begin
                if (start) nxt = P_INIT;
            end else if (m_pos == P_INIT) begin
                e_en = 1'b1; e_init = 1'b1; nxt = 0;
            end else if (m_pos == P_DONE) begin
                e_rv = 1'b1;
                if (bus.in_res_ready) nxt = P_IDLE;
            end else begin
                e_rdy = 1'b1;
                e_en  = bus.in_llr_valid;
                e_ps  = bus.in_llr_valid && (((m_pos + 1) % SEG) == 0);
                if (bus.in_llr_valid) nxt = m_pos + 1;
            end
        end
        chk("srst",        int'(bus.out_tsc_Srst),        int'(e_srst));
        chk("en",          int'(bus.out_tsc_en),          int'(e_en));
        chk("init",        int'(bus.out_tsc_init),        int'(e_init));
        chk("phase_shift", int'(bus.out_tsc_phase_shift), int'(e_ps));
        chk("llr_ready",   int'(bus.out_llr_ready),       int'(e_rdy));
        chk("res_valid",   int'(bus.out_res_valid),       int'(e_rv));
        chk("busy",        int'(busy),                    int'(e_busy));
        if (rst_n && !abort && m_pos == P_DONE) begin
            chk("alpha3_seg0", t_a3, exp_min[0]);
            chk("alpha2_seg1", t_a2, exp_min[1]);
            chk("alpha1_seg2", t_a1, exp_min[2]);
        end
        if (!rst_n || bus.out_tsc_Srst) begin
            t_cur = 7; t_a1 = 7; t_a2 = 7; t_a3 = 7;
        end else if (bus.out_tsc_en) begin
            if (bus.out_tsc_init) begin
                t_cur = 7;
            end else begin
                if (bmin < t_cur) t_cur = bmin;
                if (bus.out_tsc_phase_shift) begin
                    t_a3 = t_a2; t_a2 = t_a1; t_a1 = t_cur; t_cur = 7;
                end
            end
        end
        m_pos = nxt;
    end

    task automatic calc_exp();
        for (int g = 0; g < 3; g++) begin
            exp_min[g] = 7;
            for (int b = g * SEG; b < (g + 1) * SEG; b++)
                for (int s = 0; s < 4; s++)
                    if (int'(frame[b][s]) < exp_min[g]) exp_min[g] = int'(frame[b][s]);
        end
    endtask

    task automatic fill_const(input logic [2:0] v);
        for (int b = 0; b < NBEATS; b++)
            for (int s = 0; s < 4; s++) frame[b][s] = v;
    endtask

    task automatic fill_rand();
        for (int b = 0; b < NBEATS; b++)
            for (int s = 0; s < 4; s++) frame[b][s] = 3'($urandom_range(0, 7));
        calc_exp();
    endtask

    // Present this cycle's valid and beat, then move to just after the next rising edge.
    task automatic cyc();
        case (vmode)
            0:       bus.in_llr_valid = 1'b1;
            1:       begin bus.in_llr_valid = toggle; toggle = ~toggle; end
            default: bus.in_llr_valid = 1'($urandom_range(0, 1));
        endcase
        for (int s = 0; s < 4; s++)
            beat_sym[s] = (m_pos >= 0 && m_pos < NBEATS) ? frame[m_pos][s] : 3'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Run one frame to DONE, hold the result, then hand it off; lat returns cycles from start to DONE.
    task automatic run_frame(input int mode, input int hold, input bit rnd, output int lat);
        bit aborted;
        aborted = 1'b0;
        toggle = 1'b1;
        vmode = mode;
        start = 1'b1;
        cyc();
        lat = 1;
        while (m_pos != P_DONE && lat < 400 && !aborted) begin
            if (rnd) begin
                start = ($urandom_range(0, 7) == 0);
                abort = ($urandom_range(0, 63) == 0);
            end
            cyc();
            lat++;
            if (m_pos == P_IDLE) aborted = 1'b1;
        end
        if (aborted) begin
            lat = -1;
        end else if (m_pos != P_DONE) begin
            chk("frame_timeout", lat, -1);
        end else begin
            bus.in_res_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                start = (i % 3 == 0);
                cyc();
            end
            bus.in_res_ready = 1'b1;
            start = 1'b1;
            cyc();
            bus.in_res_ready = 1'b0;
            cyc();
            chk("idle_after_handoff", int'(busy), 0);
        end
    endtask

    int lat;

    initial begin
        bus.in_llr_valid = 1'b0;
        bus.in_res_ready = 1'b0;
        bus1.in_llr_valid = 1'b1;
        bus1.in_res_ready = 1'b0;
        fill_const(3'd7);
        calc_exp();
        for (int s = 0; s < 4; s++) beat_sym[s] = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        // Minimum 0 in beats 1, 6, 11, unstalled.
        fill_const(3'd7);
        frame[0][2] = 3'd0; frame[5][1] = 3'd0; frame[10][3] = 3'd0;
        calc_exp();
        run_frame(0, 10, 1'b0, lat);
        chk("lat_unstalled", lat, 14);
        chk("dirA_alpha3", t_a3, 0);
        chk("dirA_alpha2", t_a2, 0);
        chk("dirA_alpha1", t_a1, 0);

        // Same frame with valid toggling 1010...
        run_frame(1, 2, 1'b0, lat);
        chk("lat_toggle", lat, 25);
        chk("dirA_tog_alpha1", t_a1, 0);

        // Distinct segment minima pin the result order.
        fill_const(3'd6);
        frame[2][0] = 3'd2; frame[4][3] = 3'd5; frame[11][1] = 3'd1;
        calc_exp();
        run_frame(0, 0, 1'b0, lat);
        chk("dirB_alpha3", t_a3, 2);
        chk("dirB_alpha2", t_a2, 5);
        chk("dirB_alpha1", t_a1, 1);

        // Abort in the cycle of the 6th beat, then abort+start together in IDLE.
        vmode = 0;
        start = 1'b1;
        cyc();
        repeat (6) cyc();
        abort = 1'b1;
        #1;
        chk("abort_ready_low", int'(bus.out_llr_ready), 0);
        chk("abort_srst", int'(bus.out_tsc_Srst), 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_to_idle", int'(busy), 0);
        start = 1'b1;
        abort = 1'b1;
        cyc();
        chk("abort_beats_start", int'(busy), 0);
        run_frame(0, 1, 1'b0, lat);
        chk("after_abort_alpha1", t_a1, 1);

        // Asynchronous reset mid-RUN, off the clock edge.
        start = 1'b1;
        cyc();
        repeat (5) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", int'(bus.out_llr_ready), 0);
        chk("arst_en", int'(bus.out_tsc_en), 0);
        chk("arst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("arst_idle_after", int'(busy), 0);

        // SEG_BEATS = 1 build: three consecutive shifts, result valid on cycle 5.
        start1 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus1.in_res_ready = (c == 5);
            #1;
            chk("s1_init",  int'(bus1.out_tsc_init),        int'(c == 1));
            chk("s1_shift", int'(bus1.out_tsc_phase_shift), int'(c >= 2 && c <= 4));
            chk("s1_resv",  int'(bus1.out_res_valid),       int'(c == 5));
            chk("s1_busy",  int'(busy1),                    int'(c >= 1 && c <= 5));
            cyc();
            start1 = 1'b0;
        end
        bus1.in_res_ready = 1'b0;

        // Randomized frames with stalls, stray starts and occasional aborts.
        for (int f = 0; f < 25; f++) begin
            fill_rand();
            run_frame(2, $urandom_range(0, 5), 1'b1, lat);
            repeat (2) cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
